// File: rtl/sha_msg_padder.sv
// Packs a 64-bit big-endian word stream into 512-bit SHA-256 blocks and appends
// the 0x80 marker, zero fill and the 64-bit message bit-length.
module sha_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    input  logic [3:0]   in_bytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {FILL, PAD, OUT} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       idx_reg, idx_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic             marker_reg, marker_next;  // 0x80 still owed to slot idx
    logic             pad_reg, pad_next;        // another padding block follows this one
    logic             first_reg, first_next;
    logic             last_reg, last_next;
    logic [63:0]      buf_reg [8];

    logic             wr_en;
    logic [63:0]      wr_data;
    logic [3:0]       nbytes;
    logic [63:0]      last_word;
    logic [63:0]      len_field;

    assign nbytes    = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign len_field = 64'(len_reg);

    // Final word: keep the valid bytes, drop the marker right after them, zero the rest.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            assign last_word[63-8*gi -: 8] =
                (4'(gi) < nbytes)  ? in_data[63-8*gi -: 8] :
                (4'(gi) == nbytes) ? 8'h80 : 8'h00;
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_out
            assign blk_data[511-64*gi -: 64] = buf_reg[gi];
        end
    endgenerate

    assign in_ready  = (state_reg == FILL);
    assign blk_valid = (state_reg == OUT);
    assign blk_first = blk_valid & first_reg;
    assign blk_last  = blk_valid & last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= FILL;
            idx_reg    <= 3'd0;
            len_reg    <= '0;
            marker_reg <= 1'b0;
            pad_reg    <= 1'b0;
            first_reg  <= 1'b1;
            last_reg   <= 1'b0;
            for (int i = 0; i < 8; i++) buf_reg[i] <= 64'd0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            len_reg    <= len_next;
            marker_reg <= marker_next;
            pad_reg    <= pad_next;
            first_reg  <= first_next;
            last_reg   <= last_next;
            if (wr_en) buf_reg[idx_reg] <= wr_data;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        len_next    = len_reg;
        marker_next = marker_reg;
        pad_next    = pad_reg;
        first_next  = first_reg;
        last_next   = last_reg;
        wr_en       = 1'b0;
        wr_data     = 64'd0;
        case (state_reg)
            FILL: begin
                if (in_valid) begin
                    wr_en    = 1'b1;
                    idx_next = idx_reg + 3'd1;
                    if (!in_last) begin
                        wr_data  = in_data;
                        len_next = len_reg + LEN_W'(64);
                        if (idx_reg == 3'd7) begin
                            state_next = OUT;
                            last_next  = 1'b0;
                            pad_next   = 1'b0;
                        end
                    end else begin
                        wr_data     = last_word;
                        len_next    = len_reg + LEN_W'({nbytes, 3'b000});
                        marker_next = (nbytes == 4'd8);
                        // A last word in slot 7 leaves no room for the length here.
                        if (idx_reg == 3'd7) begin
                            state_next = OUT;
                            last_next  = 1'b0;
                            pad_next   = 1'b1;
                        end else begin
                            state_next = PAD;
                        end
                    end
                end
            end
            PAD: begin
                wr_en = 1'b1;
                if (marker_reg) begin
                    wr_data     = 64'h8000_0000_0000_0000;
                    marker_next = 1'b0;
                    if (idx_reg == 3'd7) begin
                        state_next = OUT;
                        last_next  = 1'b0;
                        pad_next   = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else if (idx_reg == 3'd7) begin
                    wr_data    = len_field;
                    state_next = OUT;
                    last_next  = 1'b1;
                    pad_next   = 1'b0;
                end else begin
                    idx_next = idx_reg + 3'd1;
                end
            end
            OUT: begin
                if (blk_ready) begin
                    idx_next   = 3'd0;
                    first_next = last_reg;
                    last_next  = 1'b0;
                    pad_next   = 1'b0;
                    state_next = pad_reg ? PAD : FILL;
                    if (last_reg) len_next = '0;
                end
            end
            default: state_next = FILL;
        endcase
    end

endmodule

// File: tb/tb_sha_msg_padder.sv
// Scoreboard bench for sha_msg_padder: a reference SHA-256 padding model queues
// expected blocks as messages are sent; a monitor pops and compares them.
module tb_sha_msg_padder;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_data = 64'd0;
    logic         in_last = 1'b0;
    logic [3:0]   in_bytes = 4'd0;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    int   checks = 0;
    int   errors = 0;
    int   blocks_seen = 0;
    blk_t sb[$];

    sha_msg_padder #(.LEN_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last)
    );

    always #5 clk = ~clk;

    // Monitor: every consumed block must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && blk_valid && blk_ready) begin
            blk_t e;
            blocks_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_block data=%h", blk_data);
            end else begin
                e = sb.pop_front();
                if (blk_data !== e.data) begin
                    errors++;
                    $display("FAIL blk_data got=%h exp=%h", blk_data, e.data);
                end
                checks++;
                if (blk_first !== e.first) begin
                    errors++;
                    $display("FAIL blk_first got=%b exp=%b", blk_first, e.first);
                end
                checks++;
                if (blk_last !== e.last) begin
                    errors++;
                    $display("FAIL blk_last got=%b exp=%b", blk_last, e.last);
                end
                $display("block %0d first=%b last=%b w0=%h w7=%h", blocks_seen,
                         blk_first, blk_last, blk_data[511:448], blk_data[63:0]);
            end
        end
    end

    // Reference padding: message || 0x80 || zeros || 64-bit big-endian bit length.
    task automatic push_model(input bq_t m);
        bq_t         p;
        logic [63:0] bl;
        int          nb;
        blk_t        e;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int i = 0; i < 8; i++) p.push_back(bl[63-8*i -: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[64*b+j];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            sb.push_back(e);
        end
    endtask

    function automatic bq_t mk_bytes(input int n, input int seed);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'((seed + i * 37) & 8'hFF));
        return q;
    endfunction

    task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends m as words; bytes past the end of the message carry junk that must be masked.
    task automatic send_bytes(input bq_t m, input logic clamp, input logic use_model);
        int          n;
        int          nw;
        int          bi;
        logic [63:0] d;
        logic [3:0]  b;
        n  = m.size();
        nw = (n == 0) ? 1 : (n + 7) / 8;
        if (use_model) push_model(m);
        for (int w = 0; w < nw; w++) begin
            for (int j = 0; j < 8; j++) begin
                bi = 8 * w + j;
                d[63-8*j -: 8] = (bi < n) ? m[bi] : 8'hA5;
            end
            b = 4'(n - 8 * (nw - 1));
            if (clamp && b == 4'd8) b = 4'hF;
            send_word(d, (w == nw - 1), b);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s drain pending got=%0d exp=0", name, sb.size());
            sb.delete();
        end
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle blk_valid=%b in_ready=%b exp 0/1", name, blk_valid, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_data !== 512'd0 ||
            blk_first !== 1'b0 || blk_last !== 1'b0) begin
            errors++;
            $display("FAIL %s reset_outputs got rdy=%b vld=%b first=%b last=%b data_nz=%b exp 1 0 0 0 0",
                     name, in_ready, blk_valid, blk_first, blk_last, |blk_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("test_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_abc();
        bq_t  q;
        blk_t e;
        q = '{8'h61, 8'h62, 8'h63};
        e.data  = {64'h6162_6380_0000_0000, 384'd0, 64'h18};
        e.first = 1'b1;
        e.last  = 1'b1;
        sb.push_back(e);
        send_bytes(q, 1'b0, 1'b0);
        wait_drain("test_abc");
    endtask

    task automatic test_empty();
        bq_t  q;
        blk_t e;
        e.data  = {64'h8000_0000_0000_0000, 448'd0};
        e.first = 1'b1;
        e.last  = 1'b1;
        sb.push_back(e);
        send_bytes(q, 1'b0, 1'b0);
        wait_drain("test_empty");
    endtask

    task automatic test_55_56_64();
        send_bytes(mk_bytes(55, 11), 1'b0, 1'b1);
        wait_drain("test_55");
        send_bytes(mk_bytes(56, 29), 1'b0, 1'b1);
        wait_drain("test_56");
        send_bytes(mk_bytes(64, 5), 1'b1, 1'b1);
        wait_drain("test_64_clamp");
    endtask

    task automatic test_back_to_back();
        logic [511:0] d0;
        logic         f0, l0;
        int           n;
        blk_ready = 1'b0;
        fork
            begin
                send_bytes(mk_bytes(20, 3), 1'b0, 1'b1);
                send_bytes(mk_bytes(70, 91), 1'b0, 1'b1);
            end
            begin
                n = 0;
                while (!blk_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (!blk_valid) begin
                    errors++;
                    $display("FAIL stall blk_valid got=0 exp=1");
                end
                d0 = blk_data;
                f0 = blk_first;
                l0 = blk_last;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    checks++;
                    if (blk_data !== d0 || blk_first !== f0 || blk_last !== l0 ||
                        blk_valid !== 1'b1 || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall cycle %0d vld=%b rdy=%b first=%b/%b last=%b/%b exp stable",
                                 c, blk_valid, in_ready, blk_first, f0, blk_last, l0);
                    end
                end
                @(posedge clk);
                #1;
                blk_ready = 1'b1;
            end
        join
        wait_drain("test_back_to_back");
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = blocks_seen;
        for (int w = 0; w < 3; w++) send_word(64'h1111_2222_3333_4444 + 64'(w), 1'b0, 4'd8);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("test_reset_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (blocks_seen != seen) begin
            errors++;
            $display("FAIL reset_mid blocks got=%0d exp=%0d", blocks_seen, seen);
        end
        test_abc();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_55_56_64();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
Consumes the 64-bit word stream produced by the stimulus/input stage and packs it into 512-bit SHA-256 message blocks. It applies standard SHA-256 padding: a 0x80 marker, zero fill, and the 64-bit big-endian message bit-length. Blocks are emitted with a valid/ready handshake to the compression core downstream. Byte order is big-endian: byte 0 is in_data[63:56], and word 0 is blk_data[511:448].

Parameters:
LEN_W, 64, width of the internal message bit-length counter; zero-extended into the 64-bit length field; wraps modulo 2^LEN_W.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  padder can accept a word this cycle
in_data  input  64  message word, big-endian bytes
in_last  input  1  word is the final word of the message
in_bytes  input  4  valid bytes in the last word, 0..8; ignored unless in_last
blk_valid  output  1  blk_data holds a complete block
blk_ready  input  1  downstream accepts the block
blk_data  output  512  padded 512-bit block
blk_first  output  1  block is the first of its message
blk_last  output  1  block is the final block of its message

Behaviour:
- Reset (async assert, sync release): state FILL, word index 0, length counter 0, buffer 0. Outputs in_ready=1, blk_valid=0, blk_data=0, blk_first=0, blk_last=0.
- Transfer rules: a word is accepted when in_valid && in_ready. A block is consumed when blk_valid && blk_ready.
- FILL state:
  - Each accepted word is written to buffer slot idx, then idx increments.
  - The length counter adds 64 per non-last word.
  - For a last word it adds 8*in_bytes.
  - Bytes at positions >= in_bytes in a last word are forced to 0.
- Last word handling:
  - If in_bytes<8: byte in_bytes of that word becomes 0x80. Call k = idx of that word.
  - If in_bytes==8: the 0x80 marker goes in byte 0 of slot idx+1 (state PAD). Call k = idx+1.
- Fill completion: when slot 7 is written and more words remain (no padding yet), go to OUT with blk_last=0.
- PAD state (one cycle per slot, in_ready=0):
  - Writes the 0x80 slot if still pending, then zero slots.
  - Once the current block holds marker and zeros through slot 6, slot 7 receives the length and the state goes to OUT with blk_last=1.
  - If k==7 (marker in slot 7, or k wraps to slot 0 of a new block), the current block is completed with zeros and emitted with blk_last=0. The following block is all zeros plus the length in slot 7, emitted with blk_last=1.
- OUT state:
  - blk_valid=1, in_ready=0; blk_data, blk_first and blk_last are held stable until the handshake.
  - On handshake: go to PAD if padding remains; otherwise go to FILL with idx=0.
  - After a blk_last handshake, also clear the length counter and arm blk_first.
- blk_first is 1 on the first block emitted after reset or after a blk_last handshake.
- Latency: blk_valid rises the cycle after the 8th word is accepted (no padding case). With padding, it rises after at most 8 PAD cycles.
- Message and block boundaries:
  - in_last with in_bytes=0 is legal; an empty message yields a single block: word0=0x8000000000000000, word7=0.
  - A new message may start the cycle after FILL is re-entered.
  - An in_bytes value >8 is treated as 8.
- Reset mid-message discards all partial state; no block is emitted.
- in_ready is 1 only in FILL.

Test Plan:
- "abc": one word 0x6162630000000000, in_last=1, in_bytes=3 -> one block. word0=0x6162638000000000, words1-6=0, word7=0x18, blk_first=1, blk_last=1.
- Empty message: in_last=1, in_bytes=0 -> one block. word0=0x8000000000000000, word7=0.
- 55 bytes: 7 words, last with in_bytes=7 -> one block. word6 ends in byte 0x80, word7=0x1B8.
- 56 bytes: 7 full words, last with in_bytes=8 -> two blocks. Block0: word7=0x8000000000000000, blk_last=0. Block1: all zero except word7=0x1C0, blk_first=0, blk_last=1.
- Backpressure: hold blk_ready=0 for 10 cycles -> blk_data, blk_first and blk_last are stable, in_ready=0, no words lost. Two back-to-back messages both get correct lengths.
- Reset mid-message: assert rst_n=0 after 3 words -> all outputs return to reset values. A following "abc" message still produces the golden block.
